// File: rtl/sar_adc_ctrl_pkg.sv
// Shared definitions for the SAR ADC controller: default sizing and FSM state encoding.
package sar_adc_ctrl_pkg;
    localparam int DEF_WIDTH       = 7;
    localparam int DEF_CMP_LATENCY = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRIAL  = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/sar_adc_if.sv
// System and comparator-side signals of the SAR controller; slave = controller view.
interface sar_adc_if #(
    parameter int WIDTH = sar_adc_ctrl_pkg::DEF_WIDTH
);
    logic             start;
    logic             cmp_result;
    logic [WIDTH-1:0] cmp_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport slave (
        input  start, cmp_result,
        output cmp_code, busy, done, dout
    );

    modport master (
        output start, cmp_result,
        input  cmp_code, busy, done, dout
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: binary search MSB->LSB against a comparator
// with registered latency, presenting trial-1 because the comparator tests ">=".
module sar_adc_ctrl
    import sar_adc_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CMP_LATENCY = DEF_CMP_LATENCY
) (
    input logic      clk,
    input logic      rst,
    sar_adc_if.slave bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(CMP_LATENCY + 1);
    localparam logic [IW-1:0] IDX_MSB   = IW'(WIDTH - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(CMP_LATENCY - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] kept;

    assign bit_mask = WIDTH'(1) << idx;
    assign trial    = result | bit_mask;
    // result already carries the trial bit; a 1 from the comparator means trial > input
    assign kept     = bus.cmp_result ? (result & ~bit_mask) : result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            result       <= '0;
            bus.cmp_code <= '0;
            bus.dout     <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_TRIAL;
                        idx      <= IDX_MSB;
                        result   <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                S_TRIAL: begin
                    result       <= trial;
                    bus.cmp_code <= trial - WIDTH'(1);
                    cnt          <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt   <= '0;
                        state <= S_DECIDE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DECIDE: begin
                    result <= kept;
                    if (idx == '0) begin
                        bus.dout <= kept;
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= S_TRIAL;
                    end
                end
                S_DONE: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: registered comparator model, table vectors, corner sequences,
// full sweep and random inputs against a binary-search reference model.
module tb_sar_adc_ctrl;
    import sar_adc_ctrl_pkg::*;

    localparam int W    = DEF_WIDTH;
    localparam int L    = DEF_CMP_LATENCY;
    localparam int CONV = W * (L + 2);
    localparam int PER  = CONV + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ain = '0;
    logic [L-1:0] pipe = '0;

    always #5 clk = ~clk;

    sar_adc_if #(.WIDTH(W)) bus();

    sar_adc_ctrl #(.WIDTH(W), .CMP_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // comparator: result = code >= ain, delayed by L registers
    always @(posedge clk) pipe <= {pipe[L-2:0], (bus.cmp_code >= ain)};
    assign bus.cmp_result = pipe[L-1];

    int n_run  = 0;
    int n_fail = 0;
    int exp_prev = 0;

    typedef struct {
        int a;
        int exp_dout;
        int exp_first;
        int exp_last;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // binary search straight from the rules: keep a bit iff trial <= input
    function automatic int ref_code(input int a, input int step);
        int r = 0;
        int t;
        for (int s = 0; s < W; s++) begin
            t = r | (1 << (W - 1 - s));
            if (s == step) return t - 1;
            if (t <= a) r = t;
        end
        return -1;
    endfunction

    function automatic int ref_result(input int a);
        int r = 0;
        int t;
        for (int s = 0; s < W; s++) begin
            t = r | (1 << (W - 1 - s));
            if (t <= a) r = t;
        end
        return r;
    endfunction

    task automatic convert(input int a, output int lat, output int d, output int first,
                           output int last, output int seq_err, output int held_err,
                           output int busy_err);
        int step;
        ain = W'(a);
        lat = -1; d = -1; first = -1; last = -1;
        seq_err = 0; held_err = 0; busy_err = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= CONV + 20; k++) begin
            @(posedge clk);
            #1;
            if ((k - 1) % (L + 2) == 0) begin
                step = (k - 1) / (L + 2);
                if (step == 0) first = int'(bus.cmp_code);
                if (step < W && int'(bus.cmp_code) !== ref_code(a, step)) seq_err++;
            end
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.done === 1'b1) begin
                lat  = k;
                d    = int'(bus.dout);
                last = int'(bus.cmp_code);
                break;
            end
            if (int'(bus.dout) !== exp_prev) held_err++;
        end
    endtask

    task automatic do_conv(input string tag, input int a, input int exp_dout,
                           input int exp_first, input int exp_last);
        int lat, d, first, last, seq_err, held_err, busy_err;
        convert(a, lat, d, first, last, seq_err, held_err, busy_err);
        check({tag, " latency"}, lat, CONV);
        check({tag, " dout"}, d, exp_dout);
        check({tag, " first_code"}, first, exp_first);
        check({tag, " last_code"}, last, exp_last);
        check({tag, " trial_seq_errs"}, seq_err, 0);
        check({tag, " dout_held_errs"}, held_err, 0);
        check({tag, " busy_low_errs"}, busy_err, 0);
        @(posedge clk);
        #1;
        check({tag, " busy_after"}, int'(bus.busy), 0);
        check({tag, " done_pulse"}, int'(bus.done), 0);
        exp_prev = exp_dout;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   ndone, dval, t0, t1, d0, d1, nd6;

        bus.start = 1'b0;
        vecs[0] = '{0,   0,   63, 0};
        vecs[1] = '{127, 127, 63, 126};
        vecs[2] = '{64,  64,  63, 64};
        vecs[3] = '{85,  85,  63, 84};
        vecs[4] = '{1,   1,   63, 0};
        vecs[5] = '{42,  42,  63, 42};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset dout", int'(bus.dout), 0);
        check("reset cmp_code", int'(bus.cmp_code), 0);
        rst = 1'b0;
        exp_prev = 0;

        foreach (vecs[i])
            do_conv($sformatf("vec%0d ain=%0d", i, vecs[i].a), vecs[i].a,
                    vecs[i].exp_dout, vecs[i].exp_first, vecs[i].exp_last);

        // start re-asserted mid-conversion and during DONE must be ignored
        ain = W'(99);
        ndone = 0; dval = -1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin ndone++; dval = int'(bus.dout); end
            bus.start = (k == 4 || k == 28);
        end
        check("ignore_start done_count", ndone, 1);
        check("ignore_start dout", dval, 99);
        check("ignore_start busy_end", int'(bus.busy), 0);
        exp_prev = 99;

        // reset mid-conversion aborts without done
        ain = W'(77);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", int'(bus.busy), 0);
        check("midrst done", int'(bus.done), 0);
        check("midrst dout", int'(bus.dout), 0);
        check("midrst cmp_code", int'(bus.cmp_code), 0);
        rst = 1'b0;
        exp_prev = 0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("midrst no_done", ndone, 0);
        do_conv("after_rst ain=42", 42, 42, 63, 42);

        // start held high: back-to-back conversions PER cycles apart
        ain = W'(10);
        t0 = -1; t1 = -1; d0 = -1; d1 = -1; nd6 = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                if (nd6 == 0) begin t0 = k; d0 = int'(bus.dout); ain = W'(100); end
                else if (nd6 == 1) begin t1 = k; d1 = int'(bus.dout); end
                nd6++;
            end
        end
        bus.start = 1'b0;
        check("held first_done_cycle", t0, CONV);
        check("held period", t1 - t0, PER);
        check("held dout0", d0, 10);
        check("held dout1", d1, 100);
        repeat (2 * PER) @(posedge clk);
        #1;
        check("held final_busy", int'(bus.busy), 0);
        exp_prev = 100;

        for (int a = 0; a < (1 << W); a++)
            do_conv($sformatf("sweep ain=%0d", a), a, ref_result(a),
                    ref_code(a, 0), ref_code(a, W - 1));

        for (int i = 0; i < 16; i++) begin
            int a;
            a = int'($urandom_range(0, (1 << W) - 1));
            do_conv($sformatf("rand ain=%0d", a), a, ref_result(a),
                    ref_code(a, 0), ref_code(a, W - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
